// File: rtl/a_edge_counter.sv
// -----------------------------------------------------------------------------
// a_edge_counter
//
// Debounces a raw single-bit input and counts its debounced rising edges into a
// WIDTH-bit up/down counter that either wraps or saturates at its bounds.
// Provides a synchronous load and a one-cycle terminal-count pulse.
//
// Parameters
//   WIDTH     counter width, q spans 0 .. 2^WIDTH-1
//   DEBOUNCE  consecutive identical samples needed to change a_filt (>= 1)
//   SATURATE  0: wrap at the bounds, 1: hold at the bounds
//
// Ports
//   clock     in   1      single clock, rising edge
//   reset_n   in   1      asynchronous active-low reset
//   a         in   1      raw input
//   dir       in   1      1: count up, 0: count down (sampled on the count edge)
//   load      in   1      synchronous load strobe, overrides counting
//   load_val  in   WIDTH  value loaded into q when load=1
//   q         out  WIDTH  counter value (registered)
//   a_filt    out  1      debounced a (registered)
//   tc        out  1      one-cycle pulse after a bound crossing / attempt
//
// Build option
//   A_SYNC_EN  when defined, a passes through a 2-FF synchroniser before the
//              debounce FSM, delaying a_filt and q by two cycles.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module a_edge_counter #(
  parameter int WIDTH    = 3,
  parameter int DEBOUNCE = 2,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             a,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             a_filt,
  output logic             tc
);

  localparam int               DB_W    = $clog2(DEBOUNCE) + 1;
  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE - 1);
  localparam logic [WIDTH-1:0] MAX     = '1;

  typedef enum logic [1:0] {LOW, RISE, HIGH, FALL} state_t;

  state_t          state_q, state_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            a_s;
  logic            count_ev;

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
`ifdef A_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], a};
    end
  end

  assign a_s = sync_q[1];
`else
  assign a_s = a;
`endif

  // ---------------------------------------------------------------------------
  // Debounce FSM: next state and count event
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // leaves a variable unassigned, which would infer a latch.
    state_d  = state_q;
    db_cnt_d = db_cnt_q;
    count_ev = 1'b0;

    unique case (state_q)
      LOW: begin
        if (a_s) begin
          if (DEBOUNCE == 1) begin
            state_d  = HIGH;
            count_ev = 1'b1;
          end else begin
            state_d  = RISE;
            db_cnt_d = DB_W'(1);
          end
        end
      end

      RISE: begin
        if (!a_s) begin
          state_d = LOW;
        end else if (db_cnt_q == DB_LAST) begin
          state_d  = HIGH;
          count_ev = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end

      HIGH: begin
        if (!a_s) begin
          if (DEBOUNCE == 1) begin
            state_d = LOW;
          end else begin
            state_d  = FALL;
            db_cnt_d = DB_W'(1);
          end
        end
      end

      FALL: begin
        // A bounce back high during the falling debounce returns to HIGH
        // without producing a second count event.
        if (a_s) begin
          state_d = HIGH;
        end else if (db_cnt_q == DB_LAST) begin
          state_d = LOW;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end

      default: state_d = LOW;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM state register; a_filt is registered from the next state so it
  // changes on the same edge as the state itself.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge values regardless of statement order.
    if (!reset_n) begin
      state_q  <= LOW;
      db_cnt_q <= '0;
      a_filt   <= 1'b0;
    end else begin
      state_q  <= state_d;
      db_cnt_q <= db_cnt_d;
      a_filt   <= (state_d == HIGH) || (state_d == FALL);
    end
  end

  // ---------------------------------------------------------------------------
  // Counter and terminal-count pulse. Load wins over a coincident count event,
  // which is then dropped entirely (no tc).
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q  <= '0;
      tc <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (load) begin
        q <= load_val;
      end else if (count_ev) begin
        if (dir) begin
          if (q == MAX) begin
            q  <= SATURATE ? MAX : '0;
            tc <= 1'b1;
          end else begin
            q <= q + WIDTH'(1);
          end
        end else begin
          if (q == '0) begin
            q  <= SATURATE ? '0 : MAX;
            tc <= 1'b1;
          end else begin
            q <= q - WIDTH'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_a_edge_counter.sv
// -----------------------------------------------------------------------------
// tb_a_edge_counter
//
// Scoreboard bench for a_edge_counter. The stimulus process pushes the expected
// {q, a_filt, tc} value for every output change it provokes; a monitor samples
// the outputs on the falling clock edge and, whenever they change, pops the
// next expected value and compares. Unexpected changes and leftover entries
// are reported as failures. A few cycle-exact latency checks are done directly.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_a_edge_counter;

  localparam int W   = 3;
  localparam bit SAT = 1'b0;
`ifdef A_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  typedef struct packed {
    logic [W-1:0] q;
    logic         af;
    logic         tc;
  } out_t;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         a;
  logic         dir;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] q;
  logic         a_filt;
  logic         tc;

  int   checks = 0;
  int   errors = 0;
  out_t exp_q[$];
  out_t last_exp;

  a_edge_counter #(
    .WIDTH   (W),
    .DEBOUNCE(2),
    .SATURATE(SAT)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .a       (a),
    .dir     (dir),
    .load    (load),
    .load_val(load_val),
    .q       (q),
    .a_filt  (a_filt),
    .tc      (tc)
  );

  always #1 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Queue an expected output value; consecutive identical values collapse
  // into one, matching the monitor's change-driven sampling.
  task automatic exp_out(input logic [W-1:0] eq, input logic eaf, input logic etc);
    out_t e;
    e = '{q: eq, af: eaf, tc: etc};
    if (e != last_exp) begin
      exp_q.push_back(e);
      last_exp = e;
    end
  endtask

  task automatic step();
    @(posedge clock);
    #0.5;
  endtask

  // One clean debounced pulse: two cycles high, then low long enough to
  // return the FSM to LOW. eq/etc are the q and tc produced by its count.
  task automatic pulse(input logic [W-1:0] eq, input logic etc);
    exp_out(eq, 1'b1, etc);
    exp_out(eq, 1'b1, 1'b0);
    exp_out(eq, 1'b0, 1'b0);
    a = 1'b1;
    repeat (2) step();
    a = 1'b0;
    repeat (2 + LAT) step();
  endtask

  task automatic do_load(input logic [W-1:0] v);
    exp_out(v, 1'b0, 1'b0);
    load     = 1'b1;
    load_val = v;
    step();
    load     = 1'b0;
  endtask

  // Monitor: compares on every observed output change outside reset.
  initial begin
    out_t prev, cur;
    prev = '0;
    forever begin
      @(negedge clock);
      cur = '{q: q, af: a_filt, tc: tc};
      if (!reset_n) begin
        prev = cur;
      end else if (cur != prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_change: got q=%0d a_filt=%0b tc=%0b, required no change",
                   cur.q, cur.af, cur.tc);
        end else begin
          check("output_change", 32'(cur), 32'(exp_q.pop_front()));
        end
        prev = cur;
      end
    end
  end

  // Expected q after each of 8 up-pulses starting from 0.
  logic [W-1:0] q_up [8];

  initial begin
    q_up = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, (SAT ? 3'd7 : 3'd0)};
    last_exp = '0;
    a        = 1'b0;
    dir      = 1'b1;
    load     = 1'b0;
    load_val = '0;
    reset_n  = 1'b1;
    #0.1;
    reset_n  = 1'b0;

    // Reset state
    repeat (3) step();
    check("reset_q", 32'(q), 32'd0);
    check("reset_a_filt", 32'(a_filt), 32'd0);
    check("reset_tc", 32'(tc), 32'd0);
    reset_n = 1'b1;

    // Test 1: a held high 10 cycles -> one count at the 2nd sampling edge
    exp_out(3'd1, 1'b1, 1'b0);
    a = 1'b1;
    repeat (1 + LAT) step();
    check("t1_a_filt_after_1st_edge", 32'(a_filt), 32'd0);
    check("t1_q_after_1st_edge", 32'(q), 32'd0);
    step();
    check("t1_a_filt_after_2nd_edge", 32'(a_filt), 32'd1);
    check("t1_q_after_2nd_edge", 32'(q), 32'd1);
    repeat (8) step();
    check("t1_q_held_high", 32'(q), 32'd1);
    exp_out(3'd1, 1'b0, 1'b0);
    a = 1'b0;
    repeat (3 + LAT) step();
    check("t1_a_filt_after_release", 32'(a_filt), 32'd0);
    check("t1_q_after_release", 32'(q), 32'd1);

    // Test 2: single-cycle glitches never reach a_filt
    a = 1'b1; step();
    a = 1'b0; step();
    a = 1'b1; step();
    a = 1'b0;
    repeat (3 + LAT) step();
    check("t2_glitch_a_filt", 32'(a_filt), 32'd0);
    check("t2_glitch_q", 32'(q), 32'd1);

    // Test 3: 8 up-pulses from 0, bound on the 8th
    do_load(3'd0);
    dir = 1'b1;
    for (int i = 0; i < 8; i++) pulse(q_up[i], i == 7);
    check("t3_final_q", 32'(q), SAT ? 32'd7 : 32'd0);

    // Test 4: down from 0 -> bound, then one more down
    do_load(3'd2);
    do_load(3'd0);
    dir = 1'b0;
    pulse(SAT ? 3'd0 : 3'd7, 1'b1);
    pulse(SAT ? 3'd0 : 3'd6, SAT);

    // Test 5: load coincident with a wrapping count event -> q=5, tc=0
    dir = 1'b1;
    do_load(3'd7);
    exp_out(3'd5, 1'b1, 1'b0);
    exp_out(3'd5, 1'b0, 1'b0);
    a = 1'b1;
    repeat (1 + LAT) step();
    load     = 1'b1;
    load_val = 3'd5;
    step();
    load     = 1'b0;
    check("t5_load_wins_q", 32'(q), 32'd5);
    check("t5_load_wins_tc", 32'(tc), 32'd0);
    a = 1'b0;
    repeat (2 + LAT) step();
    pulse(3'd6, 1'b0);
    check("t5_next_up_q", 32'(q), 32'd6);

    // Test 6: reset mid-RISE discards progress; debounce restarts afterwards
    a = 1'b1;
    repeat (1 + LAT) step();
    reset_n  = 1'b0;
    last_exp = '0;
    step();
    check("t6_reset_q", 32'(q), 32'd0);
    check("t6_reset_a_filt", 32'(a_filt), 32'd0);
    check("t6_reset_tc", 32'(tc), 32'd0);
    exp_out(3'd1, 1'b1, 1'b0);
    reset_n = 1'b1;
    repeat (1 + LAT) step();
    check("t6_a_filt_after_1st_edge", 32'(a_filt), 32'd0);
    step();
    check("t6_a_filt_after_2nd_edge", 32'(a_filt), 32'd1);
    check("t6_q_after_2nd_edge", 32'(q), 32'd1);
    exp_out(3'd1, 1'b0, 1'b0);
    a = 1'b0;
    repeat (3 + LAT) step();

    repeat (4) step();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
